// File: rtl/traffic_ctrl_timed.sv
// rtl/traffic_ctrl_timed.sv - highway/country intersection controller with phase timers and night flash
// Outputs decode only the state register and blink flop, so sensor inputs never reach the lamps combinationally.
module traffic_ctrl_timed #(
   parameter int unsigned Y2R_DELAY      = 3,
   parameter int unsigned R2G_DELAY      = 2,
   parameter int unsigned HWY_MIN_GREEN  = 8,
   parameter int unsigned CTRY_MAX_GREEN = 10,
   parameter int unsigned FLASH_HALF     = 4,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       X,
   input  logic       night_mode,
   output logic [1:0] H,
   output logic [1:0] C,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_HG    = 3'd0,
      S_HY    = 3'd1,
      S_AR1   = 3'd2,
      S_CG    = 3'd3,
      S_CY    = 3'd4,
      S_AR2   = 3'd5,
      S_FLASH = 3'd6
   } state_t;

   localparam logic [1:0] L_RED = 2'b00;
   localparam logic [1:0] L_YEL = 2'b01;
   localparam logic [1:0] L_GRN = 2'b10;
   localparam logic [1:0] L_OFF = 2'b11;

   localparam logic [CNT_W-1:0] LD_HG    = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_YEL   = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] LD_RED   = CNT_W'(R2G_DELAY - 1);
   localparam logic [CNT_W-1:0] LD_CG    = CNT_W'(CTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_FLASH = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             blink_q, blink_d;
   logic             tmr_zero;

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_HG;
         timer_q <= LD_HG;
         blink_q <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         blink_q <= blink_d;
      end
   end

   assign tmr_zero = (timer_q == '0);

   // Every state change reloads the timer; otherwise it counts down and sticks at zero.
   always_comb begin
      state_d = state_q;
      timer_d = tmr_zero ? timer_q : (timer_q - ONE);
      blink_d = 1'b1;
      case (state_q)
         S_HG: begin
            if (night_mode) begin
               state_d = S_FLASH;
               timer_d = LD_FLASH;
            end else if (tmr_zero && X) begin
               state_d = S_HY;
               timer_d = LD_YEL;
            end
         end
         S_HY: begin
            if (tmr_zero) begin
               state_d = S_AR1;
               timer_d = LD_RED;
            end
         end
         S_AR1: begin
            if (tmr_zero) begin
               state_d = S_CG;
               timer_d = LD_CG;
            end
         end
         S_CG: begin
            if (!X || tmr_zero) begin
               state_d = S_CY;
               timer_d = LD_YEL;
            end
         end
         S_CY: begin
            if (tmr_zero) begin
               state_d = S_AR2;
               timer_d = LD_RED;
            end
         end
         S_AR2: begin
            if (tmr_zero) begin
               state_d = S_HG;
               timer_d = LD_HG;
            end
         end
         S_FLASH: begin
            blink_d = blink_q;
            if (!night_mode) begin
               state_d = S_AR2;
               timer_d = LD_RED;
               blink_d = 1'b1;
            end else if (tmr_zero) begin
               blink_d = ~blink_q;
               timer_d = LD_FLASH;
            end
         end
         default: begin
            state_d = S_HG;
            timer_d = LD_HG;
         end
      endcase
   end

   always_comb begin
      H = L_RED;
      C = L_RED;
      case (state_q)
         S_HG:  H = L_GRN;
         S_HY:  H = L_YEL;
         S_CG:  C = L_GRN;
         S_CY:  C = L_YEL;
         S_FLASH: begin
            if (blink_q) begin
               H = L_YEL;
            end else begin
               H = L_OFF;
               C = L_OFF;
            end
         end
         default: begin
            H = L_RED;
            C = L_RED;
         end
      endcase
   end

   assign state_o = state_q;

endmodule

// File: doc/traffic_ctrl_timed.md
Name: traffic_ctrl_timed

Overview:
Parametrised highway/country-road intersection controller. It replaces fixed behavioural delays with real down-counter timers and adds a minimum highway green, a maximum country green, and symmetric all-red clearance intervals. It also adds a night flashing mode. It sits at the top of the signal path, and its light outputs drive the lamp drivers directly.

Parameters:
Y2R_DELAY, 3, cycles each yellow phase lasts (>=1)
R2G_DELAY, 2, cycles each all-red clearance lasts (>=1)
HWY_MIN_GREEN, 8, minimum cycles of highway green before yielding (>=1)
CTRY_MAX_GREEN, 10, maximum cycles of country green (>=1)
FLASH_HALF, 4, cycles per on/off half-period in night mode (>=1)
CNT_W, 8, timer width; must hold max(all delays)-1

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
X  in  1  country-road car sensor, 1 = car waiting
night_mode  in  1  request for flashing mode
H  out  2  highway light: 00=R, 01=Y, 10=G, 11=OFF
C  out  2  country light, same encoding
state_o  out  3  current state, for debug/verification

Behaviour:
- Outputs are a pure decode of the state register plus the blink flop. There is no combinational path from X or night_mode to H or C.
- State encoding:
  - S_HG=0: H=G, C=R
  - S_HY=1: H=Y, C=R
  - S_AR1=2: H=R, C=R
  - S_CG=3: H=R, C=G
  - S_CY=4: H=R, C=Y
  - S_AR2=5: H=R, C=R
  - S_FLASH=6: see night mode
  - Code 7 is illegal and goes to S_HG on the next edge.
- Reset, asserted asynchronously at any time including mid-phase:
  - state=S_HG, H=G, C=R, state_o=0
  - timer=HWY_MIN_GREEN-1, blink=1
  - Release is synchronous-safe; the first edge after release counts as HG cycle 2.
- Timer:
  - On every state entry, timer loads (phase length - 1).
  - It decrements each cycle while nonzero and saturates at 0.
  - Phase length is HWY_MIN_GREEN in HG, Y2R_DELAY in HY and CY, R2G_DELAY in AR1 and AR2, CTRY_MAX_GREEN in CG, and FLASH_HALF in FLASH.
- Transitions, evaluated at each rising edge:
  - S_HG:
    - night_mode=1 → S_FLASH, regardless of timer; this has priority over X.
    - Otherwise, timer==0 && X → S_HY.
    - Otherwise stay. Timer holds 0, so once the minimum green has elapsed, X causes H=Y on the very next edge.
  - S_HY: timer==0 → S_AR1. The phase lasts exactly Y2R_DELAY cycles.
  - S_AR1: timer==0 → S_CG. The phase lasts exactly R2G_DELAY cycles.
  - S_CG: X==0 || timer==0 → S_CY. Minimum 1 cycle, maximum CTRY_MAX_GREEN cycles.
  - S_CY: timer==0 → S_AR2.
  - S_AR2: timer==0 → S_HG, with the timer reloaded to HWY_MIN_GREEN-1.
  - S_FLASH: night_mode==0 → S_AR2, which gives a clearance before highway green.
- Night mode:
  - night_mode is honoured only in S_HG and ignored in every other state until HG is reached.
  - In S_FLASH, blink starts at 1 on entry and toggles each time the timer reaches 0; the timer then reloads FLASH_HALF-1.
  - blink=1 drives H=Y, C=R. blink=0 drives H=OFF, C=OFF.
- X and night_mode are treated as already synchronous; synchronisers are external.
- Simultaneous events:
  - X=1 with night_mode=1 in HG → FLASH.
  - X toggling during HY, AR1, CY or AR2 has no effect.
  - Any X=0 sample in CG ends green on that edge.
- Safety invariant: H and C are never both in {G, Y} in the same cycle. Every change of road right-of-way passes through an all-red phase.

Test Plan:
1. Default parameters. Reset asserted for 3 cycles mid-CG → H=G, C=R immediately without waiting for a clock. After release with X=0, night_mode=0 → H=G, C=R held for 100 cycles.
2. X=1 continuously from reset release → HG 8 cycles, HY 3, AR1 2, CG 10 (max green), CY 3, AR2 2, then HG 8 again. state_o sequence is 0,1,2,3,4,5,0 with exactly those dwell times.
3. X=0 until cycle 20, then X=1 → H=Y on the edge after X is sampled. X then drops after 4 CG cycles → CG lasts exactly 4 cycles, followed by CY for 3.
4. X=1 in HG, then X=0 during AR1 → CG held exactly 1 cycle, then CY.
5. night_mode=1 asserted during HY → ignored until HG is reached, then FLASH on the next edge. In FLASH, H=Y/C=R for 4 cycles, then OFF/OFF for 4, repeating. Dropping night_mode → AR2 for 2 cycles, then HG with an 8-cycle minimum.
6. X=1 and night_mode=1 together in HG with min green elapsed → S_FLASH, not S_HY. Across all scenarios, an assertion checks that H and C are never both in {G, Y}.
